// File: rtl/tcam_entry_writer.sv
// FracTCAM entry writer: turns one entry-write request into a full sweep
// of LUTRAM column writes. Each cycle of the sweep presents one LUT address,
// shared by all slices, along with the match bit that every slice stores at
// that address for the selected entry column.
module tcam_entry_writer #(
  parameter  int DATA_WIDTH  = 10,
  parameter  int DEPTH       = 8,
  parameter  int SLICE_WIDTH = 5,
  localparam int SLICE_NUM   = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH,
  localparam int IDX_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [IDX_WIDTH-1:0]   wr_index_i,
  input  logic [DATA_WIDTH-1:0]  wr_key_i,
  input  logic [DATA_WIDTH-1:0]  wr_mask_i,
  input  logic                   wr_enable_i,
  output logic                   mem_wr_en_o,
  output logic [SLICE_WIDTH-1:0] mem_wr_addr_o,
  output logic [DEPTH-1:0]       mem_wr_sel_o,
  output logic [SLICE_NUM-1:0]   mem_wr_data_o,
  output logic                   wr_done_o,
  output logic                   wr_err_o
);

  // Key and mask are held zero-extended to a whole number of slices, so the
  // padding bits of the last slice behave as don't-care.
  localparam int PAD_WIDTH = SLICE_NUM * SLICE_WIDTH;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]             state_q,    state_d;
  logic [SLICE_WIDTH-1:0] addr_q,     addr_d;
  logic [PAD_WIDTH-1:0]   key_q,      key_d;
  logic [PAD_WIDTH-1:0]   mask_q,     mask_d;
  logic                   enable_q,   enable_d;
  logic                   in_range_q, in_range_d;
  logic                   mem_en_q,   mem_en_d;
  logic [DEPTH-1:0]       mem_sel_q,  mem_sel_d;
  logic [SLICE_NUM-1:0]   mem_data_q, mem_data_d;
  logic                   done_q,     done_d;
  logic                   err_q,      err_d;

  // A slice stores 1 at a LUT address when every cared-about key bit of
  // that slice equals the corresponding address bit.
  function automatic logic [SLICE_NUM-1:0] sliceMatch(
    input logic [SLICE_WIDTH-1:0] addr,
    input logic [PAD_WIDTH-1:0]   key,
    input logic [PAD_WIDTH-1:0]   mask,
    input logic                   enable
  );
    logic [SLICE_NUM-1:0] hit;
    hit = '0;
    for (int s = 0; s < SLICE_NUM; s++) begin
      hit[s] = enable &
               (((addr ^ key[s*SLICE_WIDTH +: SLICE_WIDTH]) &
                 mask[s*SLICE_WIDTH +: SLICE_WIDTH]) == '0);
    end
    return hit;
  endfunction

  // Indices past DEPTH only exist when DEPTH is not a power of two.
  function automatic logic indexInRange(input logic [IDX_WIDTH-1:0] idx);
    return {1'b0, idx} < (IDX_WIDTH + 1)'(DEPTH);
  endfunction

  logic                 acc_in_range;
  logic [PAD_WIDTH-1:0] acc_key;
  logic [PAD_WIDTH-1:0] acc_mask;

  assign acc_in_range = indexInRange(wr_index_i);
  assign acc_key      = PAD_WIDTH'(wr_key_i);
  assign acc_mask     = PAD_WIDTH'(wr_mask_i);

  // Ready is forced low while reset is asserted so no request slips in.
  assign wr_ready_o = (state_q == IDLE) & ~rst_i;

  // Next-state logic: latch the request in IDLE, then step the LUT address
  // once per cycle and pre-compute the registered write-port outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    key_d      = key_q;
    mask_d     = mask_q;
    enable_d   = enable_q;
    in_range_d = in_range_q;
    mem_en_d   = mem_en_q;
    mem_sel_d  = mem_sel_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_valid_i) begin
          state_d    = WRITE;
          addr_d     = '0;
          key_d      = acc_key;
          mask_d     = acc_mask;
          enable_d   = wr_enable_i;
          in_range_d = acc_in_range;
          mem_en_d   = acc_in_range;
          mem_sel_d  = acc_in_range ? (DEPTH'(1) << wr_index_i) : '0;
          mem_data_d = acc_in_range ?
                       sliceMatch('0, acc_key, acc_mask, wr_enable_i) : '0;
        end
      end
      WRITE: begin
        if (addr_q == '1) begin
          state_d    = IDLE;
          addr_d     = '0;
          mem_en_d   = 1'b0;
          mem_sel_d  = '0;
          mem_data_d = '0;
        end else begin
          addr_d     = addr_q + 1'b1;
          mem_data_d = in_range_q ?
                       sliceMatch(addr_d, key_q, mask_q, enable_q) : '0;
          done_d     = (addr_d == '1);
          err_d      = (addr_d == '1) & ~in_range_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      key_q      <= '0;
      mask_q     <= '0;
      enable_q   <= 1'b0;
      in_range_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_sel_q  <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      key_q      <= key_d;
      mask_q     <= mask_d;
      enable_q   <= enable_d;
      in_range_q <= in_range_d;
      mem_en_q   <= mem_en_d;
      mem_sel_q  <= mem_sel_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_wr_en_o   = mem_en_q;
  assign mem_wr_addr_o = addr_q;
  assign mem_wr_sel_o  = mem_sel_q;
  assign mem_wr_data_o = mem_data_q;
  assign wr_done_o     = done_q;
  assign wr_err_o      = err_q;

endmodule

// File: doc/tcam_entry_writer.md
Name: tcam_entry_writer

Overview:
- Programming-side counterpart of the FracTCAM lookup path: the lookup path reads match lines; this block writes them.
- Accepts one entry-write request (index, key, mask, enable) per handshake and expands it into LUTRAM column writes for the FracTCAM storage.
- Each write sweeps every LUT address of every slice.
- Sits between the control-plane register interface and the TCAM storage write port.

Parameters:
- DATA_WIDTH, 10, key/mask width in bits.
- DEPTH, 8, number of TCAM entries (match lines).
- SLICE_WIDTH, 5, key bits per LUTRAM slice; each slice has 2^SLICE_WIDTH addresses.
- SLICE_NUM, derived = ceil(DATA_WIDTH/SLICE_WIDTH), slices per entry (local, not overridable).
- IDX_WIDTH, derived = max(1, clog2(DEPTH)), index width (local).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  request valid.
- wr_ready  output  1  block can accept a request.
- wr_index  input  IDX_WIDTH  target entry.
- wr_key  input  DATA_WIDTH  entry key.
- wr_mask  input  DATA_WIDTH  care mask; 1 = compare bit, 0 = don't care.
- wr_enable  input  1  1 = install entry, 0 = invalidate (all match bits written 0).
- mem_wr_en  output  1  storage write strobe.
- mem_wr_addr  output  SLICE_WIDTH  LUT address being written (shared by all slices).
- mem_wr_sel  output  DEPTH  one-hot entry column select.
- mem_wr_data  output  SLICE_NUM  match bit per slice for mem_wr_addr.
- wr_done  output  1  one-cycle pulse: request completed.
- wr_err  output  1  one-cycle pulse with wr_done: index out of range.

Behaviour:
- Reset values: wr_ready=0 during rst, 1 on the first cycle after; all other outputs 0. Internal state returns to IDLE.
- FSM states:
  - IDLE: wr_ready=1. On wr_valid&wr_ready at edge T, latch index/key/mask/enable, clear the address counter, go to WRITE.
  - WRITE: wr_ready=0, mem_wr_en=1. The counter advances by 1 per cycle.
- Write timing: cycles T+1 .. T+2^SLICE_WIDTH drive mem_wr_addr = 0,1,...,2^SLICE_WIDTH-1 in order. The counter wraps to 0 when the block returns to IDLE.
- Completion: wr_done pulses in the cycle carrying the last address (T+2^SLICE_WIDTH). wr_ready is high again at T+2^SLICE_WIDTH+1, giving a 2^SLICE_WIDTH+1 cycle request-to-request minimum.
- mem_wr_data[s] = enable AND (((addr XOR key_s) AND mask_s) == 0), where key_s and mask_s are bits [s*SLICE_WIDTH +: SLICE_WIDTH].
- Padding: bits of the last slice above DATA_WIDTH take key=0, mask=0 (don't care).
- mem_wr_sel = one-hot(latched index) while mem_wr_en=1, else 0. All mem_* outputs are registered and mutually aligned.
- Out-of-range index (index >= DEPTH, only possible when DEPTH is not a power of 2):
  - request is accepted and the sweep timing is unchanged;
  - mem_wr_en stays 0 and mem_wr_sel=0;
  - wr_done and wr_err pulse together.
- wr_valid while busy is ignored (not accepted). Inputs are sampled only at the accept edge; later changes have no effect.
- Reset mid-WRITE aborts immediately: outputs go to 0 on the next cycle and the partially written entry is left as is. Software must rewrite it.
- rst has priority over a simultaneous handshake.

Test Plan:
- Basic install: after reset, write index 3, key 0x2A5, mask 0x3FF, enable 1 → exactly 32 strobes with mem_wr_sel=0x08.
  - mem_wr_data=2'b01 only at addr 5; 2'b10 only at addr 21; 0 elsewhere.
  - wr_done at strobe 32; wr_ready high one cycle later.
- Don't-care: index 0, key 0x000, mask 0x01F → slice0 bit=1 only at addr 0; slice1 bit=1 at all 32 addresses.
- Invalidate: index 7, enable 0, any key/mask → 32 strobes, mem_wr_data=0 throughout, mem_wr_sel=0x80.
- Back-to-back: hold wr_valid high with two requests → second is accepted exactly 33 cycles after the first; wr_ready is low during all 32 write cycles.
- Reset mid-sweep: assert rst at strobe 10 → mem_wr_en=0 next cycle, no wr_done pulse, wr_ready=1 the cycle after rst deasserts.
- DEPTH=6, index 6 → no mem_wr_en for the full sweep; wr_done and wr_err both pulse on the 32nd cycle.
